// File: rtl/serial_compare_ctrl.sv
// Sequencer for a bit-serial magnitude comparator: accepts a parallel operand pair,
// clears the comparator, streams the bits LSB-first and hands back the captured verdict.
module serial_compare_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result_gt,
  output logic             result_eq,
  output logic             result_lt,
  output logic             busy,
  output logic             cmp_a,
  output logic             cmp_b,
  output logic             cmp_clear,
  input  logic             cmp_greater,
  input  logic             cmp_equal,
  input  logic             cmp_less
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_out_fire;

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_last_bit = (r_state == S_SHIFT) && (r_cnt == LAST_CNT);
  assign w_out_fire = (r_state == S_DONE) && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_next = S_CLEAR;
      S_CLEAR:  w_state_next = S_SHIFT;
      S_SHIFT:  if (w_last_bit) w_state_next = S_SETTLE;
      S_SETTLE: w_state_next = S_DONE;
      S_DONE:   if (w_out_fire) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Counter holds at WIDTH-1 on the final shift so it never leaves the 0..WIDTH-1 range.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_cnt <= '0;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sa  <= op_a;
        r_sb  <= op_b;
        r_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_sa <= r_sa >> 1;
        r_sb <= r_sb >> 1;
        if (!w_last_bit) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (r_state == S_SETTLE) begin
        r_gt <= cmp_greater;
        r_eq <= cmp_equal;
        r_lt <= cmp_less;
      end
    end
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    out_valid = (r_state == S_DONE);
    cmp_clear = (r_state == S_CLEAR) || !reset;
    cmp_a     = (r_state == S_SHIFT) && r_sa[0];
    cmp_b     = (r_state == S_SHIFT) && r_sb[0];
  end

  assign result_gt = r_gt;
  assign result_eq = r_eq;
  assign result_lt = r_lt;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed and randomised bench for serial_compare_ctrl with a behavioural
// bit-serial comparator attached to the cmp_* port.
module tb_serial_compare_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic         result_gt;
  logic         result_eq;
  logic         result_lt;
  logic         busy;
  logic         cmp_a;
  logic         cmp_b;
  logic         cmp_clear;
  logic         cmp_greater;
  logic         cmp_equal;
  logic         cmp_less;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result_gt   (result_gt),
    .result_eq   (result_eq),
    .result_lt   (result_lt),
    .busy        (busy),
    .cmp_a       (cmp_a),
    .cmp_b       (cmp_b),
    .cmp_clear   (cmp_clear),
    .cmp_greater (cmp_greater),
    .cmp_equal   (cmp_equal),
    .cmp_less    (cmp_less)
  );

  // Comparator model: 0 = equal, 1 = greater, 2 = less; a later differing bit overrides.
  logic [1:0] cmp_st = 2'd0;
  always @(posedge clk) begin
    if (cmp_clear)          cmp_st <= 2'd0;
    else if (cmp_a && !cmp_b) cmp_st <= 2'd1;
    else if (!cmp_a && cmp_b) cmp_st <= 2'd2;
  end
  assign cmp_greater = (cmp_st == 2'd1);
  assign cmp_less    = (cmp_st == 2'd2);
  assign cmp_equal   = (cmp_st == 2'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called right after the accept edge; counts edges until out_valid.
  task automatic wait_result(output int lat, output logic [W-1:0] aseq, output int nclr);
    lat  = 0;
    aseq = '0;
    nclr = 0;
    while (!out_valid && lat < 40) begin
      if (cmp_clear) nclr++;
      if (lat >= 1 && lat <= W) aseq[lat-1] = cmp_a;
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] aseq);
    int lat;
    int nclr;
    logic egt, eeq, elt;
    egt = (a > b);
    eeq = (a == b);
    elt = (a < b);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_result(lat, aseq, nclr);
    check({tag, "_latency"}, 32'(lat), 32'(W + 2));
    check({tag, "_clear_cycles"}, 32'(nclr), 32'd1);
    check({tag, "_gt"}, 32'(result_gt), 32'(egt));
    check({tag, "_eq"}, 32'(result_eq), 32'(eeq));
    check({tag, "_lt"}, 32'(result_lt), 32'(elt));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_held"}, {29'd0, result_gt, result_eq, result_lt}, {29'd0, egt, eeq, elt});
    $display("op %s a=%02h b=%02h lat=%0d gt=%0b eq=%0b lt=%0b", tag, a, b, lat,
             result_gt, result_eq, result_lt);
  endtask

  initial begin
    logic [W-1:0] aseq;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int lat;
    int nclr;

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmp_clear", 32'(cmp_clear), 32'd1);
    check("rst_cmp_ab", {30'd0, cmp_a, cmp_b}, 32'd0);
    check("rst_results", {29'd0, result_gt, result_eq, result_lt}, 32'd0);
    reset = 1'b1;
    tick();
    check("run_cmp_clear", 32'(cmp_clear), 32'd0);

    do_op("a80_b7f", 8'h80, 8'h7F, aseq);
    check("a80_cmp_a_seq", 32'(aseq), 32'h80);

    // Abort mid-SHIFT with reset
    op_a     = 8'hF0;
    op_b     = 8'h0F;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_cmp_clear", 32'(cmp_clear), 32'd1);
    check("abort_results", {29'd0, result_gt, result_eq, result_lt}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    $display("op abort a=f0 b=0f reset mid-shift");

    do_op("a01_b02", 8'h01, 8'h02, aseq);
    check("a01_cmp_a_seq", 32'(aseq), 32'h01);
    do_op("a5a_b5a", 8'h5A, 8'h5A, aseq);
    do_op("aff_b00", 8'hFF, 8'h00, aseq);
    do_op("a00_bff", 8'h00, 8'hFF, aseq);

    // Back-to-back with a stalled consumer and in_valid held high
    op_a     = 8'h33;
    op_b     = 8'h44;
    in_valid = 1'b1;
    tick();
    op_a = 8'hC0;
    op_b = 8'h0C;
    wait_result(lat, aseq, nclr);
    check("b2b_first_latency", 32'(lat), 32'(W + 2));
    for (int i = 0; i < 5; i++) begin
      check("b2b_wait_valid", 32'(out_valid), 32'd1);
      check("b2b_wait_in_ready", 32'(in_ready), 32'd0);
      check("b2b_wait_result", {29'd0, result_gt, result_eq, result_lt}, 32'b001);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b2b_idle_in_ready", 32'(in_ready), 32'd1);
    check("b2b_idle_busy", 32'(busy), 32'd0);
    tick();
    in_valid = 1'b0;
    check("b2b_second_accepted", 32'(busy), 32'd1);
    wait_result(lat, aseq, nclr);
    check("b2b_second_latency", 32'(lat), 32'(W + 2));
    check("b2b_second_result", {29'd0, result_gt, result_eq, result_lt}, 32'b100);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("op b2b a=33,c0 b=44,0c results lt then gt");

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = (i % 10 == 0) ? ra : W'($urandom_range(0, 255));
      do_op("rand", ra, rb, aseq);
      check("rand_cmp_a_seq", 32'(aseq), 32'(ra));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
